move_selector: RTL
==================

// Module: move_selector
// PURPOSE
//   Player-input front end for the tic-tac-toe game FSM. Turns raw pushbuttons into a
//   debounced cursor on the 3x3 board and issues one validated move per confirm press.
//   Rejects moves on occupied cells. Feeds move_x/move_y to the game block with a
//   valid/ready handshake.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button level is accepted (10 ms @ 50 MHz)
//   CNT_W            20      width of each debounce counter; must hold DEBOUNCE_CYCLES
// PORTS
//   clock        in   1  system clock, all logic on rising edge
//   reset        in   1  asynchronous, active-low reset
//   btn_up       in   1  raw pushbutton, active-high, asynchronous to clock
//   btn_down     in   1  raw pushbutton, active-high, asynchronous to clock
//   btn_left     in   1  raw pushbutton, active-high, asynchronous to clock
//   btn_right    in   1  raw pushbutton, active-high, asynchronous to clock
//   btn_confirm  in   1  raw pushbutton, active-high, asynchronous to clock
//   enable       in   1  game accepts a player move this cycle (player's turn, game not over)
//   occupied     in   9  board occupancy from the game block, bit index = 3*y + x
//   move_ready   in   1  game block accepts the offered move
//   cursor_x     out  2  current cursor column, 0..2
//   cursor_y     out  2  current cursor row, 0..2
//   move_valid   out  1  move_x/move_y hold a validated move
//   move_x       out  2  column of the offered move
//   move_y       out  2  row of the offered move
//   reject       out  1  1-cycle pulse: confirm pressed on an occupied cell
// BEHAVIOUR
//   Reset (reset=0, async): all outputs 0, cursor (0,0), FSM=SELECT, synchronizers, debounce
//     counters and debounced levels cleared. Valid immediately, including mid-handshake.
//   Input conditioning, per button:
//     - 2-flop synchronizer.
//     - Counter clears whenever the synced level equals the debounced level; otherwise it
//       increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the
//       counter clears.
//     - press = 1-cycle pulse on a debounced 0->1 edge.
//     - Latency from raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
//   Cursor (moves only in SELECT):
//     - Left/right decrement/increment x; up/down decrement/increment y (row 0 is top).
//     - Wraps: 2+1 -> 0, 0-1 -> 2.
//     - Axes are independent: a diagonal press in one cycle moves both.
//     - Opposing presses in the same cycle on one axis leave that axis unchanged.
//   FSM states:
//     SELECT:
//       - press_confirm & enable & occupied[3*cursor_y+cursor_x] -> reject=1 for one
//         cycle, stay in SELECT.
//       - press_confirm & enable & cell free -> latch move_x=cursor_x, move_y=cursor_y,
//         move_valid=1 on the next cycle, go to OFFER.
//       - press_confirm with enable=0 is ignored (no reject).
//     OFFER:
//       - move_valid=1; move_x/move_y stable.
//       - Direction presses and confirm presses are ignored.
//       - The transfer occurs on the cycle move_valid & move_ready. move_valid drops the
//         next cycle; go to RELEASE.
//       - enable falling in OFFER does not withdraw the move.
//     RELEASE:
//       - Wait until the debounced confirm level is 0, then go to SELECT.
//       - Prevents one held press from issuing two moves.
//   - move_valid never asserts in the same cycle as reject.
//   - The cursor keeps its position after a move.
// TESTING (DEBOUNCE_CYCLES=4)
//   - Bounce: btn_right toggles every 2 cycles for 20 cycles, then held high -> exactly
//     one cursor_x step 0->1, 6 cycles after the last toggle.
//   - Wrap: 3 right presses from (0,0) -> cursor_x 1,2,0. 1 up press -> cursor_y=2.
//     Simultaneous up+down -> y unchanged.
//   - Valid move: cursor (2,1), occupied=0, enable=1, confirm, move_ready=0 for 5 cycles
//     then 1 -> move_valid held 5+ cycles with move_x=2, move_y=1. Drops 1 cycle after
//     the handshake.
//   - Occupied: occupied=9'b000100000 (bit 5), cursor (2,1), confirm -> one reject
//     pulse, move_valid stays 0.
//   - Held confirm: confirm held 50 cycles, move_ready=1 -> exactly one move transfer.
//     A second move only after release and a new press. enable=0 + confirm -> no
//     reject, no move.
//   - Reset mid-OFFER: reset=0 while move_valid=1 -> move_valid=0 and cursor (0,0)
//     asynchronously. After reset release, FSM is in SELECT.

Source files
------------

// File: rtl/move_selector_if.sv
// Move handshake between the player front end and the game block: move_x/move_y qualified by valid/ready.
// Master offers the move; slave accepts it with move_ready.
interface move_selector_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_x;
  logic [1:0] move_y;

  modport master (output move_valid, output move_x, output move_y, input move_ready);
  modport slave  (input move_valid, input move_x, input move_y, output move_ready);
endinterface

// File: rtl/move_selector.sv
// Debounced 3x3 cursor plus one validated move per confirm press; press fires DEBOUNCE_CYCLES+2 after a raw edge.
// A move is held on moveBus until move_ready; held confirm cannot issue a second move until released.
module move_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       enable,
  input  logic [8:0] occupied,
  output logic [1:0] cursor_x,
  output logic [1:0] cursor_y,
  output logic       reject,
  move_selector_if.master moveBus
);

  localparam int UP = 0;
  localparam int DOWN = 1;
  localparam int LEFT = 2;
  localparam int RIGHT = 3;
  localparam int CONFIRM = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SELECT, OFFER, RELEASE} selState;

  logic [4:0]            btnRaw;
  logic [4:0]            syncA;
  logic [4:0]            syncB;
  logic [4:0]            level;
  logic [4:0][CNT_W-1:0] cnt;
  logic [4:0]            press;

  selState    state;
  selState    stateNext;
  logic [1:0] xNext;
  logic [1:0] yNext;
  logic [1:0] moveX;
  logic [1:0] moveY;
  logic [1:0] moveXNext;
  logic [1:0] moveYNext;
  logic       rejectNext;
  logic [3:0] cellIdx;

  assign btnRaw = {btn_confirm, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncA <= '0;
      syncB <= '0;
      level <= '0;
      cnt   <= '0;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
      for (int i = 0; i < 5; i++) begin
        if (syncB[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press is raised in the cycle whose edge flips the debounced level high,
  // so the consumer acts on the same edge the level changes.
  always_comb begin
    press = '0;
    for (int i = 0; i < 5; i++) begin
      press[i] = syncB[i] & ~level[i] & (cnt[i] == CNT_LAST);
    end
  end

  function automatic logic [1:0] stepAxis(input logic [1:0] pos, input logic dec, input logic inc);
    logic [1:0] res;
    res = pos;
    if (inc && !dec) begin
      res = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
    end else if (dec && !inc) begin
      res = (pos == 2'd0) ? 2'd2 : pos - 2'd1;
    end
    return res;
  endfunction

  assign cellIdx = 4'(cursor_y) * 4'd3 + 4'(cursor_x);

  always_comb begin
    stateNext  = state;
    xNext      = cursor_x;
    yNext      = cursor_y;
    moveXNext  = moveX;
    moveYNext  = moveY;
    rejectNext = 1'b0;
    case (state)
      SELECT: begin
        xNext = stepAxis(cursor_x, press[LEFT], press[RIGHT]);
        yNext = stepAxis(cursor_y, press[UP], press[DOWN]);
        if (press[CONFIRM] && enable) begin
          if (occupied[cellIdx]) begin
            rejectNext = 1'b1;
          end else begin
            moveXNext = cursor_x;
            moveYNext = cursor_y;
            stateNext = OFFER;
          end
        end
      end
      OFFER: begin
        if (moveBus.move_ready) begin
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        if (!level[CONFIRM]) begin
          stateNext = SELECT;
        end
      end
      default: stateNext = SELECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SELECT;
      cursor_x <= 2'd0;
      cursor_y <= 2'd0;
      moveX    <= 2'd0;
      moveY    <= 2'd0;
      reject   <= 1'b0;
    end else begin
      state    <= stateNext;
      cursor_x <= xNext;
      cursor_y <= yNext;
      moveX    <= moveXNext;
      moveY    <= moveYNext;
      reject   <= rejectNext;
    end
  end

  assign moveBus.move_valid = (state == OFFER);
  assign moveBus.move_x     = moveX;
  assign moveBus.move_y     = moveY;

endmodule
